// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the target and controller sides: FSM states, byte size, R/W bit encoding.
package i2c_pkg;

    localparam int   BITS_PER_BYTE = 8;
    localparam logic I2C_RW_WRITE  = 1'b0;
    localparam logic I2C_RW_READ   = ~I2C_RW_WRITE;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_REG,
        ST_REG_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_WAIT_STOP
    } i2c_target_state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizer plus edge-detect flop for one bus line; level/rise/fall valid STAGES clocks after the pad.
// Flops reset high to match an idle (pulled-up) bus so reset release never looks like an edge.
module i2c_line_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic line_i,
    output logic level_o,
    output logic prev_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], line_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign prev_o  = prev_q;
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/i2c_target.sv
// I2C/SCCB target with a synchronous register port; read support under I2C_TARGET_READ_EN.
// Latency: pad edge to action SYNC_STAGES+1 clocks; no backpressure, SCL is never stretched.
import i2c_pkg::*;

module i2c_target #(
    parameter logic [6:0] DEVICE_ADDR = 7'h21,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe_o,
    output logic [7:0] reg_addr_o,
    output logic [7:0] reg_wr_data_o,
    output logic       reg_wr_en_o,
    input  logic [7:0] reg_rd_data_i,
    output logic       busy_o,
    output logic       nack_o
);

    logic scl_lvl, scl_prev, scl_rise, scl_fall;
    logic sda_lvl, sda_prev, sda_rise, sda_fall;

    i2c_line_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .line_i    (scl_i),
        .level_o   (scl_lvl),
        .prev_o    (scl_prev),
        .rise_o    (scl_rise),
        .fall_o    (scl_fall)
    );

    i2c_line_sync #(.STAGES(SYNC_STAGES)) u_sda_sync (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .line_i    (sda_i),
        .level_o   (sda_lvl),
        .prev_o    (sda_prev),
        .rise_o    (sda_rise),
        .fall_o    (sda_fall)
    );

    logic start_det, stop_det, sda_bit, rd_req, last_bit;
    logic [7:0] byte_in;

    i2c_target_state_t state;
    logic [3:0]        bit_cnt;
    logic [6:0]        shift_q;
`ifdef I2C_TARGET_READ_EN
    logic              rw_q;
`else
    logic              unused_rd_data;
    assign unused_rd_data = ^reg_rd_data_i;
`endif

    // START/STOP only while SCL is steadily high, so an SCL edge always wins over an SDA change
    assign start_det = scl_lvl & scl_prev & sda_fall;
    assign stop_det  = scl_lvl & scl_prev & sda_rise;
    assign sda_bit   = (sda_rise | sda_fall) ? sda_prev : sda_lvl;
    assign byte_in   = {shift_q, sda_bit};
    assign rd_req    = (sda_bit == I2C_RW_READ);
    assign last_bit  = (bit_cnt == 4'(BITS_PER_BYTE - 1));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state         <= ST_IDLE;
            bit_cnt       <= '0;
            shift_q       <= '0;
            sda_oe_o      <= 1'b0;
            reg_addr_o    <= '0;
            reg_wr_data_o <= '0;
            reg_wr_en_o   <= 1'b0;
            busy_o        <= 1'b0;
            nack_o        <= 1'b0;
`ifdef I2C_TARGET_READ_EN
            rw_q          <= 1'b0;
`endif
        end else begin
            reg_wr_en_o <= 1'b0;
            nack_o      <= 1'b0;
            if (reg_wr_en_o)
                reg_addr_o <= reg_addr_o + 8'd1;

            if (start_det) begin
                state    <= ST_ADDR;
                bit_cnt  <= '0;
                busy_o   <= 1'b1;
                sda_oe_o <= 1'b0;
            end else if (stop_det) begin
                state    <= ST_IDLE;
                bit_cnt  <= '0;
                busy_o   <= 1'b0;
                sda_oe_o <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR, ST_REG, ST_WDATA: begin
                        if (scl_rise) begin
                            shift_q <= byte_in[6:0];
                            bit_cnt <= bit_cnt + 4'd1;
                            if (last_bit) begin
                                bit_cnt <= '0;
                                if (state == ST_ADDR) begin
                                    if (byte_in[7:1] != DEVICE_ADDR) begin
                                        nack_o <= 1'b1;
                                        state  <= ST_WAIT_STOP;
                                    end
`ifdef I2C_TARGET_READ_EN
                                    else begin
                                        rw_q  <= rd_req;
                                        state <= ST_ADDR_ACK;
                                    end
`else
                                    else if (rd_req) begin
                                        nack_o <= 1'b1;
                                        state  <= ST_WAIT_STOP;
                                    end else begin
                                        state <= ST_ADDR_ACK;
                                    end
`endif
                                end else if (state == ST_REG) begin
                                    reg_addr_o <= byte_in;
                                    state      <= ST_REG_ACK;
                                end else begin
                                    reg_wr_data_o <= byte_in;
                                    reg_wr_en_o   <= 1'b1;
                                    state         <= ST_WDATA_ACK;
                                end
                            end
                        end
                    end

                    // ACK slot: pull SDA on the fall after bit 8, release on the next fall
                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe_o) begin
                                sda_oe_o <= 1'b1;
                            end else begin
                                sda_oe_o <= 1'b0;
                                state    <= ST_REG;
`ifdef I2C_TARGET_READ_EN
                                if (rw_q == I2C_RW_READ) begin
                                    shift_q  <= reg_rd_data_i[6:0];
                                    sda_oe_o <= ~reg_rd_data_i[7];
                                    bit_cnt  <= 4'd1;
                                    state    <= ST_RDATA;
                                end
`endif
                            end
                        end
                    end

                    ST_REG_ACK, ST_WDATA_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe_o) begin
                                sda_oe_o <= 1'b1;
                            end else begin
                                sda_oe_o <= 1'b0;
                                state    <= ST_WDATA;
                            end
                        end
                    end

`ifdef I2C_TARGET_READ_EN
                    // bit_cnt counts bits already placed on SDA; the 9th fall hands SDA to the master
                    ST_RDATA: begin
                        if (scl_fall) begin
                            if (bit_cnt == 4'(BITS_PER_BYTE)) begin
                                sda_oe_o   <= 1'b0;
                                reg_addr_o <= reg_addr_o + 8'd1;
                                bit_cnt    <= '0;
                                state      <= ST_RDATA_ACK;
                            end else begin
                                sda_oe_o <= ~shift_q[6];
                                shift_q  <= {shift_q[5:0], 1'b0};
                                bit_cnt  <= bit_cnt + 4'd1;
                            end
                        end
                    end

                    ST_RDATA_ACK: begin
                        if (scl_rise && sda_bit) begin
                            state <= ST_WAIT_STOP;
                        end else if (scl_fall) begin
                            shift_q  <= reg_rd_data_i[6:0];
                            sda_oe_o <= ~reg_rd_data_i[7];
                            bit_cnt  <= 4'd1;
                            state    <= ST_RDATA;
                        end
                    end
`endif

                    default: begin
                        sda_oe_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
